invsqrt_feeder: RTL and testbench

Upstream feed stage for `invsqrt_pipeline`. It accepts IEEE‑754 single‑precision operands on a valid/ready stream and buffers them in a small FIFO. It classifies each operand and drives the pipeline's `ce` and 31‑bit operand. A class tag and valid bit travel in a delay line that advances on `ce`, so each tag emerges aligned with the pipeline's `float_out`. Special operands (zero, negative, inf, NaN, denormal) still occupy a pipeline slot, carrying 1.0 as the substituted operand, which preserves result ordering for the downstream result mux.

---
 rtl/invsqrt_pkg.sv | 33 +++
 rtl/invsqrt_in_fifo.sv | 63 ++++++
 rtl/invsqrt_feeder.sv | 74 +++++++
 tb/tb_invsqrt_feeder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/invsqrt_pkg.sv
// Shared types and helpers for the inverse-square-root feed path:
// operand classes, the 1.0 substitute operand and the classifier.
package invsqrt_pkg;

    typedef enum logic [2:0] {
        NORMAL = 3'd0,
        ZERO   = 3'd1,
        NEG    = 3'd2,
        INF    = 3'd3,
        NAN    = 3'd4,
        DENORM = 3'd5
    } cls_e;

    localparam logic [31:0] ONE_F           = 32'h3F80_0000;
    localparam int          INVSQRT_LATENCY = 4;

    // NaN is tested before sign so that negative NaNs stay NaN; -0 is ZERO.
    function automatic cls_e classify(input logic [31:0] w);
        logic        sgn;
        logic [7:0]  ex;
        logic [22:0] man;
        sgn = w[31];
        ex  = w[30:23];
        man = w[22:0];
        if (ex == 8'hFF && man != 23'd0) return NAN;
        if (ex == 8'h00 && man == 23'd0) return ZERO;
        if (sgn)                         return NEG;
        if (ex == 8'hFF)                 return INF;
        if (ex == 8'h00)                 return DENORM;
        return NORMAL;
    endfunction

endpackage

// File: rtl/invsqrt_in_fifo.sv
// DEPTH x 32 synchronous operand FIFO with registered ready; pop requests
// while empty are ignored so the caller can drive it straight from ce.
module invsqrt_in_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    input  logic [31:0]              s_data,
    output logic                     s_ready,
    input  logic                     pop,
    output logic [31:0]              head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_C   = (AW + 1)'(1);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count_next;
    logic        push;
    logic        do_pop;

    assign count  = wr_ptr - rd_ptr;
    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign push   = s_valid && s_ready;
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr[AW-1:0]];

    always_comb begin
        count_next = count;
        if (push && !do_pop)
            count_next = count + ONE_C;
        else if (!push && do_pop)
            count_next = count - ONE_C;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            s_ready <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ONE_C;
            if (do_pop)
                rd_ptr <= rd_ptr + ONE_C;
            s_ready <= (count_next != DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= s_data;
    end

endmodule

// File: rtl/invsqrt_feeder.sv
// Feed stage for invsqrt_pipeline: buffers operands, substitutes 1.0 for
// special classes and carries a {valid, class} tag aligned with float_out.
module invsqrt_feeder
    import invsqrt_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LATENCY = INVSQRT_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        hold,
    output logic        ce,
    output logic [30:0] op_out,
    output logic        res_valid,
    output logic [2:0]  res_tag
);

    logic [31:0]              head;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    cls_e                     head_cls;
    logic                     inflight;
    logic                     adv;
    logic [LATENCY-1:0]       vld_p;
    cls_e                     tag_p [LATENCY];

    invsqrt_in_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .pop     (ce),
        .head    (head),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    assign head_cls = classify(head);
    assign inflight = |vld_p;
    // Keep clocking while anything is in flight so the last result drains out.
    assign ce       = !hold && (!empty || inflight);
    assign op_out   = (!empty && head_cls == NORMAL) ? head[30:0] : ONE_F[30:0];

    // Stage 0 .. LATENCY-1: tag delay line, advancing in lockstep with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int i = 0; i < LATENCY; i++)
                tag_p[i] <= NORMAL;
            adv <= 1'b0;
        end else begin
            adv <= ce;
            if (ce) begin
                vld_p[0] <= !empty;
                tag_p[0] <= empty ? NORMAL : head_cls;
                for (int i = 1; i < LATENCY; i++) begin
                    vld_p[i] <= vld_p[i-1];
                    tag_p[i] <= tag_p[i-1];
                end
            end
        end
    end

    // Output: adv makes the pulse last one cycle even if hold freezes the last stage.
    assign res_valid = adv && vld_p[LATENCY-1];
    assign res_tag   = tag_p[LATENCY-1];

endmodule

// File: tb/tb_invsqrt_feeder.sv
// Scoreboard bench for invsqrt_feeder against a queue-based behavioural model.
module tb_invsqrt_feeder;

    localparam int DEPTH = 8;
    localparam int L     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = 32'd0;
    logic        hold = 1'b0;
    logic        ce;
    logic [30:0] op_out;
    logic        res_valid;
    logic [2:0]  res_tag;

    int compared = 0;
    int failed   = 0;

    typedef struct {
        logic [2:0] tag;
        int         cnt;
    } fl_t;

    logic [31:0] mq[$];      // operands waiting in the FIFO
    fl_t         flight[$];  // real items launched and still inside the pipeline
    logic [2:0]  exp_q[$];   // expected result tags in acceptance order
    logic        exp_pulse = 1'b0;
    logic        exp_ready = 1'b0;
    bit          done = 1'b0;

    invsqrt_feeder #(.DEPTH(DEPTH), .LATENCY(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .hold      (hold),
        .ce        (ce),
        .op_out    (op_out),
        .res_valid (res_valid),
        .res_tag   (res_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_cls(input logic [31:0] w);
        logic        neg = w[31];
        logic [7:0]  e   = w[30:23];
        logic [22:0] m   = w[22:0];
        if (e == 8'hFF) return (m != 23'd0) ? 3'd4 : (neg ? 3'd2 : 3'd3);
        if (e == 8'h00 && m == 23'd0) return 3'd1;
        if (neg) return 3'd2;
        if (e == 8'h00) return 3'd5;
        return 3'd0;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 7))
            0: return {r[31], 31'h0};
            1: return {1'b0, 8'hFF, 23'h0};
            2: return {r[31], 8'hFF, r[22:1], 1'b1};
            3: return {1'b0, 8'h00, r[22:1], 1'b1};
            4: return {1'b1, r[30:0]};
            default: return {1'b0, 8'(r[7:0] % 8'd254 + 8'd1), r[30:8]};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: advances at each clock edge from pre-edge values.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            flight.delete();
            exp_q.delete();
            exp_pulse <= 1'b0;
            exp_ready <= 1'b0;
        end else begin
            logic p;
            p = 1'b0;
            if (ce) begin
                foreach (flight[i]) flight[i].cnt++;
                while (flight.size() != 0 && flight[0].cnt > L) void'(flight.pop_front());
                if (mq.size() != 0) begin
                    fl_t f;
                    f.tag = ref_cls(mq.pop_front());
                    f.cnt = 1;
                    flight.push_back(f);
                end
                foreach (flight[i]) if (flight[i].cnt == L) p = 1'b1;
            end
            if (s_valid && s_ready) begin
                mq.push_back(s_data);
                exp_q.push_back(ref_cls(s_data));
            end
            exp_pulse <= p;
            exp_ready <= (mq.size() != DEPTH);
        end
    end

    // Monitor: mid-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [30:0] exp_op;
        logic [31:0] hd;
        logic        exp_ce;
        exp_op = 31'h3F80_0000;
        if (mq.size() != 0) begin
            hd = mq[0];
            if (ref_cls(hd) == 3'd0) exp_op = hd[30:0];
        end
        exp_ce = rst_n && !hold && (mq.size() != 0 || flight.size() != 0);
        chk("ce", 32'(ce), 32'(exp_ce));
        chk("op_out", 32'(op_out), 32'(exp_op));
        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("res_valid", 32'(res_valid), 32'(exp_pulse));
        if (!rst_n)
            chk("rst_res_tag", 32'(res_tag), 32'd0);
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                failed++;
                $display("FAIL res_spurious at %0t: got pulse tag %0d, expected no pulse", $time, res_tag);
            end else begin
                chk("res_tag", 32'(res_tag), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [31:0] w);
        int n = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        compared++;
        if (n >= 300) begin
            failed++;
            $display("FAIL send_timeout at %0t: ready stuck 0, expected 1", $time);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        s_valid = 1'b0;
        hold    = 1'b0;
        while ((exp_q.size() != 0 || ce) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        compared++;
        if (n >= 500) begin
            failed++;
            $display("FAIL %s_drain: %0d results outstanding, expected 0", nm, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal stream
        send(32'h3E00_0000);
        send(32'h3E80_0000);
        send(32'h3F00_0000);
        drain("normal");

        // Special operands
        send(32'h8000_0000);
        send(32'hC000_0000);
        send(32'h7F80_0000);
        send(32'h7FC0_0000);
        send(32'h0000_0001);
        drain("special");

        // Fill under hold, then offer a ninth word that must be refused
        hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) send(rand_word());
        s_valid = 1'b1;
        s_data  = 32'h4000_0000;
        for (int i = 0; i < 3; i++) begin
            chk("full_ready", 32'(s_ready), 32'd0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        drain("full");

        // Hold toggling every 3 cycles during a 10-item stream
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(rand_word());
                done = 1'b1;
            end
            begin
                while (!done) begin
                    repeat (3) @(posedge clk);
                    #1 hold = ~hold;
                end
            end
        join
        drain("hold");

        // Single-item flush
        send(32'h4080_0000);
        drain("flush");

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = rand_word();
            hold    = ($urandom_range(0, 4) == 0);
            @(posedge clk); #1;
        end
        drain("random");

        // Reset with 3 items in flight and 5 queued
        send(32'h3F00_0000);
        send(32'h4000_0000);
        send(32'h4100_0000);
        @(posedge clk); #1;
        hold = 1'b1;
        for (int i = 0; i < 5; i++) send(32'h4200_0000 + 32'(i));
        rst_n = 1'b0;
        #1;
        chk("rst_async_ready", 32'(s_ready), 32'd0);
        chk("rst_async_valid", 32'(res_valid), 32'd0);
        chk("rst_async_op", 32'(op_out), 32'h3F80_0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hold = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_no_results", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
